// File: rtl/id_ex_hazard_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_hazard_stage_if
// Brief    : Decode-side, execute-side and status bundle of the ID/EX stage.
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_hazard_stage_if #(
    parameter int XLEN    = 32,
    parameter int CTRL_W  = 8,
    parameter int COUNT_W = 16
);
    logic                if_id_valid;
    logic [4:0]          if_id_rs1, if_id_rs2, if_id_rd;
    logic                if_id_use_rs1, if_id_use_rs2;
    logic [XLEN-1:0]     if_id_pc, if_id_rs1_data, if_id_rs2_data, if_id_imm;
    logic                if_id_reg_write, if_id_mem_read, if_id_mem_write;
    logic [CTRL_W-1:0]   if_id_ctrl;
    logic                ex_branch_taken;
    logic                mem_stall;

    logic                pc_write, if_id_write, if_id_flush;

    logic                id_ex_valid;
    logic [4:0]          id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic                id_ex_use_rs1, id_ex_use_rs2;
    logic [XLEN-1:0]     id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic                id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
    logic [CTRL_W-1:0]   id_ex_ctrl;

    logic [COUNT_W-1:0]  bubble_count, flush_count, hold_count;
    logic                hold_timeout;

    modport master (
        output if_id_valid, if_id_rs1, if_id_rs2, if_id_rd, if_id_use_rs1, if_id_use_rs2,
               if_id_pc, if_id_rs1_data, if_id_rs2_data, if_id_imm,
               if_id_reg_write, if_id_mem_read, if_id_mem_write, if_id_ctrl,
               ex_branch_taken, mem_stall,
        input  pc_write, if_id_write, if_id_flush,
               id_ex_valid, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_use_rs1, id_ex_use_rs2,
               id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
               id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_ctrl,
               bubble_count, flush_count, hold_count, hold_timeout
    );

    modport slave (
        input  if_id_valid, if_id_rs1, if_id_rs2, if_id_rd, if_id_use_rs1, if_id_use_rs2,
               if_id_pc, if_id_rs1_data, if_id_rs2_data, if_id_imm,
               if_id_reg_write, if_id_mem_read, if_id_mem_write, if_id_ctrl,
               ex_branch_taken, mem_stall,
        output pc_write, if_id_write, if_id_flush,
               id_ex_valid, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_use_rs1, id_ex_use_rs2,
               id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
               id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_ctrl,
               bubble_count, flush_count, hold_count, hold_timeout
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_hazard_stage
// Brief    : ID/EX register with load-use bubble, branch flush, stall hold.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_hazard_stage #(
    parameter int XLEN     = 32,
    parameter int CTRL_W   = 8,
    parameter int COUNT_W  = 16,
    parameter int MAX_HOLD = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    id_ex_hazard_stage_if.slave  bus
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

    typedef struct packed {
        logic              valid;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              use_rs1;
        logic              use_rs2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_t;

    id_ex_t             id_ex_d, id_ex_q, w_incoming;
    state_t             state_d, state_q;
    logic [HOLD_W-1:0]  hold_run_d, hold_run_q;
    logic               hold_timeout_d, hold_timeout_q;
    logic [COUNT_W-1:0] bubble_count_d, bubble_count_q;
    logic [COUNT_W-1:0] flush_count_d, flush_count_q;
    logic [COUNT_W-1:0] hold_count_d, hold_count_q;
    logic               w_lu_hazard;
    logic               w_pc_write, w_if_id_write, w_if_id_flush;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + {{(COUNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        w_incoming.valid     = bus.if_id_valid;
        w_incoming.rs1       = bus.if_id_rs1;
        w_incoming.rs2       = bus.if_id_rs2;
        w_incoming.rd        = bus.if_id_rd;
        w_incoming.use_rs1   = bus.if_id_use_rs1;
        w_incoming.use_rs2   = bus.if_id_use_rs2;
        w_incoming.pc        = bus.if_id_pc;
        w_incoming.rs1_data  = bus.if_id_rs1_data;
        w_incoming.rs2_data  = bus.if_id_rs2_data;
        w_incoming.imm       = bus.if_id_imm;
        w_incoming.reg_write = bus.if_id_reg_write;
        w_incoming.mem_read  = bus.if_id_mem_read;
        w_incoming.mem_write = bus.if_id_mem_write;
        w_incoming.ctrl      = bus.if_id_ctrl;
    end

    // Only a load still sitting in EX forces a bubble; everything else forwards.
    assign w_lu_hazard = bus.if_id_valid & id_ex_q.valid & id_ex_q.mem_read &
                         (id_ex_q.rd != 5'd0) &
                         ((bus.if_id_use_rs1 & (bus.if_id_rs1 == id_ex_q.rd)) |
                          (bus.if_id_use_rs2 & (bus.if_id_rs2 == id_ex_q.rd)));

    always_comb begin
        id_ex_d        = id_ex_q;
        bubble_count_d = bubble_count_q;
        flush_count_d  = flush_count_q;
        hold_count_d   = hold_count_q;
        w_pc_write     = 1'b0;
        w_if_id_write  = 1'b0;
        w_if_id_flush  = 1'b0;
        if (reset) begin
            w_if_id_flush = 1'b1;
        end else if (bus.mem_stall) begin
            hold_count_d = sat_inc(hold_count_q);
        end else if (bus.ex_branch_taken) begin
            id_ex_d       = '0;
            w_pc_write    = 1'b1;
            w_if_id_write = 1'b1;
            w_if_id_flush = 1'b1;
            flush_count_d = sat_inc(flush_count_q);
        end else if (w_lu_hazard) begin
            id_ex_d        = '0;
            bubble_count_d = sat_inc(bubble_count_q);
        end else begin
            id_ex_d       = w_incoming;
            w_pc_write    = 1'b1;
            w_if_id_write = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_run_d = hold_run_q;
        case (state_q)
            ST_RUN: begin
                if (bus.mem_stall) begin
                    state_d    = ST_HOLD;
                    hold_run_d = HOLD_W'(1);
                end
            end
            ST_HOLD: begin
                if (bus.mem_stall) begin
                    if (hold_run_q != HOLD_W'(MAX_HOLD))
                        hold_run_d = hold_run_q + HOLD_W'(1);
                end else begin
                    state_d    = ST_RUN;
                    hold_run_d = '0;
                end
            end
            default: begin
                state_d    = ST_RUN;
                hold_run_d = '0;
            end
        endcase
        hold_timeout_d = hold_timeout_q | (hold_run_d == HOLD_W'(MAX_HOLD));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q        <= '0;
            state_q        <= ST_RUN;
            hold_run_q     <= '0;
            hold_timeout_q <= 1'b0;
            bubble_count_q <= '0;
            flush_count_q  <= '0;
            hold_count_q   <= '0;
        end else begin
            id_ex_q        <= id_ex_d;
            state_q        <= state_d;
            hold_run_q     <= hold_run_d;
            hold_timeout_q <= hold_timeout_d;
            bubble_count_q <= bubble_count_d;
            flush_count_q  <= flush_count_d;
            hold_count_q   <= hold_count_d;
        end
    end

    assign bus.pc_write        = w_pc_write;
    assign bus.if_id_write     = w_if_id_write;
    assign bus.if_id_flush     = w_if_id_flush;
    assign bus.id_ex_valid     = id_ex_q.valid;
    assign bus.id_ex_rs1       = id_ex_q.rs1;
    assign bus.id_ex_rs2       = id_ex_q.rs2;
    assign bus.id_ex_rd        = id_ex_q.rd;
    assign bus.id_ex_use_rs1   = id_ex_q.use_rs1;
    assign bus.id_ex_use_rs2   = id_ex_q.use_rs2;
    assign bus.id_ex_pc        = id_ex_q.pc;
    assign bus.id_ex_rs1_data  = id_ex_q.rs1_data;
    assign bus.id_ex_rs2_data  = id_ex_q.rs2_data;
    assign bus.id_ex_imm       = id_ex_q.imm;
    assign bus.id_ex_reg_write = id_ex_q.reg_write;
    assign bus.id_ex_mem_read  = id_ex_q.mem_read;
    assign bus.id_ex_mem_write = id_ex_q.mem_write;
    assign bus.id_ex_ctrl      = id_ex_q.ctrl;
    assign bus.bubble_count    = bubble_count_q;
    assign bus.flush_count     = flush_count_q;
    assign bus.hold_count      = hold_count_q;
    assign bus.hold_timeout    = hold_timeout_q;
endmodule
`default_nettype wire
